// File: rtl/brisc_pkg.sv
// Shared decode-stage definitions: scoreboard FSM states and the stall-cause
// encoding reported by the scan printer.
package brisc_pkg;

  localparam int REG_SEL_BITS_DEF = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    QUIESCENT = 2'd2
  } sb_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_RS1   = 3'd1,
    CAUSE_RS2   = 3'd2,
    CAUSE_WAW   = 3'd3,
    CAUSE_FULL  = 3'd4,
    CAUSE_STATE = 3'd5,
    CAUSE_FLUSH = 3'd6
  } stall_cause_t;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode <-> scoreboard signal bundle. The master side is decode/writeback,
// the slave side is the scoreboard itself.
interface decode_scoreboard_if #(
  parameter int REG_SEL_BITS = 5,
  parameter int MAX_INFLIGHT = 4
);
  localparam int NREG  = 1 << REG_SEL_BITS;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic                    issue_valid;
  logic [REG_SEL_BITS-1:0] issue_rs1;
  logic [REG_SEL_BITS-1:0] issue_rs2;
  logic [REG_SEL_BITS-1:0] issue_rd;
  logic                    uses_rs1;
  logic                    uses_rs2;
  logic                    writes_rd;
  logic                    wb_valid;
  logic [REG_SEL_BITS-1:0] wb_reg;
  logic                    flush;
  logic                    drain_req;
  logic                    scan;
  logic                    stall;
  logic                    issue_fire;
  logic                    quiescent;
  logic [NREG-1:0]         busy;
  logic [CNT_W-1:0]        inflight;
  logic                    wb_error;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           uses_rs1, uses_rs2, writes_rd,
           wb_valid, wb_reg, flush, drain_req, scan,
    input  stall, issue_fire, quiescent, busy, inflight, wb_error
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           uses_rs1, uses_rs2, writes_rd,
           wb_valid, wb_reg, flush, drain_req, scan,
    output stall, issue_fire, quiescent, busy, inflight, wb_error
  );

endinterface

// File: rtl/hazard_check.sv
// Pure combinational RAW/WAW/capacity hazard detector over the busy vector,
// with a prioritised cause code for debug.
module hazard_check
  import brisc_pkg::*;
#(
  parameter int REG_SEL_BITS = REG_SEL_BITS_DEF
) (
  input  logic [(1<<REG_SEL_BITS)-1:0] i_busy,
  input  logic [REG_SEL_BITS-1:0]      i_rs1,
  input  logic [REG_SEL_BITS-1:0]      i_rs2,
  input  logic [REG_SEL_BITS-1:0]      i_rd,
  input  logic                         i_uses_rs1,
  input  logic                         i_uses_rs2,
  input  logic                         i_writes_rd,
  input  logic                         i_at_limit,
  output logic                         o_hazard,
  output stall_cause_t                 o_cause
);

  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_full;
  logic w_rd_live;

  // x0 is never busy, so rs=0 / rd=0 fall out naturally; rd=0 also never
  // consumes an in-flight slot.
  assign w_rd_live = i_writes_rd & (|i_rd);
  assign w_raw1    = i_uses_rs1 & i_busy[i_rs1];
  assign w_raw2    = i_uses_rs2 & i_busy[i_rs2];
  assign w_waw     = w_rd_live & i_busy[i_rd];
  assign w_full    = w_rd_live & i_at_limit;

  assign o_hazard = w_raw1 | w_raw2 | w_waw | w_full;

  always_comb begin
    o_cause = CAUSE_NONE;
    if (w_raw1)      o_cause = CAUSE_RS1;
    else if (w_raw2) o_cause = CAUSE_RS2;
    else if (w_waw)  o_cause = CAUSE_WAW;
    else if (w_full) o_cause = CAUSE_FULL;
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Register scoreboard and issue controller for decode: tracks pending writes,
// stalls on hazards/capacity, and implements the drain/quiesce handshake.
module decode_scoreboard
  import brisc_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int REG_SEL_BITS    = REG_SEL_BITS_DEF,
  parameter int MAX_INFLIGHT    = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input logic               clock,
  input logic               reset,
  decode_scoreboard_if.slave sb
);

  localparam int NREG  = 1 << REG_SEL_BITS;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  sb_state_t        r_state;
  sb_state_t        w_state_nxt;
  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_nxt;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic             r_wb_error;
  int               r_cycle;

  logic             w_at_limit;
  logic             w_hazard;
  stall_cause_t     w_cause;
  stall_cause_t     w_scan_cause;
  logic             w_stall;
  logic             w_fire;
  logic             w_set;
  logic             w_wb_live;
  logic             w_clr;
  logic             w_wb_bad;

  assign w_at_limit = (r_inflight == CNT_W'(MAX_INFLIGHT));

  hazard_check #(
    .REG_SEL_BITS (REG_SEL_BITS)
  ) u_hazard (
    .i_busy      (r_busy),
    .i_rs1       (sb.issue_rs1),
    .i_rs2       (sb.issue_rs2),
    .i_rd        (sb.issue_rd),
    .i_uses_rs1  (sb.uses_rs1),
    .i_uses_rs2  (sb.uses_rs2),
    .i_writes_rd (sb.writes_rd),
    .i_at_limit  (w_at_limit),
    .o_hazard    (w_hazard),
    .o_cause     (w_cause)
  );

  assign w_stall = sb.issue_valid & (w_hazard | (r_state != RUN) | sb.flush);
  assign w_fire  = sb.issue_valid & ~w_stall;
  assign w_set   = w_fire & sb.writes_rd & (|sb.issue_rd);

  // Writebacks in a flush cycle are dropped entirely, including error detection.
  assign w_wb_live = sb.wb_valid & (|sb.wb_reg) & ~sb.flush;
  assign w_clr     = w_wb_live & r_busy[sb.wb_reg];
  assign w_wb_bad  = w_wb_live & ~r_busy[sb.wb_reg];

  // Set is applied after clear so a same-register collision leaves it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr)    w_busy_nxt[sb.wb_reg]   = 1'b0;
    if (w_set)    w_busy_nxt[sb.issue_rd] = 1'b1;
    if (sb.flush) w_busy_nxt              = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_set)    w_inflight_nxt = w_inflight_nxt + 1'b1;
    if (w_clr)    w_inflight_nxt = w_inflight_nxt - 1'b1;
    if (sb.flush) w_inflight_nxt = '0;
  end

  // RUN goes straight to QUIESCENT when nothing is left in flight, so an idle
  // pipe reports quiescent one cycle after drain_req.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (sb.drain_req)
          w_state_nxt = (w_inflight_nxt == '0) ? QUIESCENT : DRAIN;
      end
      DRAIN: begin
        if (!sb.drain_req)              w_state_nxt = RUN;
        else if (w_inflight_nxt == '0)  w_state_nxt = QUIESCENT;
      end
      QUIESCENT: begin
        if (!sb.drain_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_busy     <= '0;
      r_inflight <= '0;
      r_wb_error <= 1'b0;
      r_cycle    <= 0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
      r_wb_error <= r_wb_error | w_wb_bad;
      r_cycle    <= r_cycle + 1;
    end
  end

  assign sb.stall      = w_stall;
  assign sb.issue_fire = w_fire;
  assign sb.quiescent  = (r_state == QUIESCENT);
  assign sb.busy       = r_busy;
  assign sb.inflight   = r_inflight;
  assign sb.wb_error   = r_wb_error;

  always_comb begin
    w_scan_cause = CAUSE_NONE;
    if (sb.issue_valid) begin
      if (sb.flush)            w_scan_cause = CAUSE_FLUSH;
      else if (r_state != RUN) w_scan_cause = CAUSE_STATE;
      else                     w_scan_cause = w_cause;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && sb.scan && (r_cycle >= SCAN_CYCLES_MIN) && (r_cycle <= SCAN_CYCLES_MAX))
      $display("[sb%0d] cyc=%0d state=%s busy=%h inflight=%0d cause=%s",
               CORE, r_cycle, r_state.name(), r_busy, r_inflight, w_scan_cause.name());
  end
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed and randomized bench for decode_scoreboard against a set-of-busy-
// registers reference model (in-flight count is the size of that set).
module tb_decode_scoreboard;

  localparam int RSB  = 5;
  localparam int NR   = 1 << RSB;
  localparam int MAXF = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decode_scoreboard_if #(.REG_SEL_BITS(RSB), .MAX_INFLIGHT(MAXF)) sb ();

  decode_scoreboard #(
    .CORE            (0),
    .REG_SEL_BITS    (RSB),
    .MAX_INFLIGHT    (MAXF),
    .SCAN_CYCLES_MIN (0),
    .SCAN_CYCLES_MAX (1000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb)
  );

  // Reference model: mode 0=RUN 1=DRAIN 2=QUIESCENT
  bit m_busy[NR];
  int m_mode;
  bit m_err;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += m_busy[i];
    return c;
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic set_issue(input bit v, input int rs1, input bit u1, input int rs2,
                           input bit u2, input int rd, input bit w);
    sb.issue_valid = v;
    sb.issue_rs1   = RSB'(rs1);
    sb.uses_rs1    = u1;
    sb.issue_rs2   = RSB'(rs2);
    sb.uses_rs2    = u2;
    sb.issue_rd    = RSB'(rd);
    sb.writes_rd   = w;
  endtask

  task automatic set_wb(input bit v, input int r);
    sb.wb_valid = v;
    sb.wb_reg   = RSB'(r);
  endtask

  task automatic idle();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    sb.flush = 1'b0;
  endtask

  // One clock: combinational checks mid-cycle, model update at the edge,
  // registered checks just after the edge. Returns on the next negedge.
  task automatic tick(input string tag);
    bit hz, st, fr;
    int cnt;
    #1;
    cnt = m_count();
    hz = (sb.uses_rs1 && m_busy[sb.issue_rs1]) ||
         (sb.uses_rs2 && m_busy[sb.issue_rs2]) ||
         (sb.writes_rd && sb.issue_rd != 0 && (m_busy[sb.issue_rd] || cnt == MAXF));
    st = sb.issue_valid && (hz || m_mode != 0 || sb.flush);
    fr = sb.issue_valid && !st;
    if (!reset) begin
      check({tag, ".stall"}, 64'(sb.stall), 64'(st));
      check({tag, ".fire"},  64'(sb.issue_fire), 64'(fr));
    end
    @(posedge clock);
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_mode = 0;
      m_err  = 0;
    end else begin
      if (sb.flush) begin
        foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
        if (sb.wb_valid && sb.wb_reg != 0) begin
          if (m_busy[sb.wb_reg]) m_busy[sb.wb_reg] = 0;
          else m_err = 1;
        end
        if (fr && sb.writes_rd && sb.issue_rd != 0) m_busy[sb.issue_rd] = 1;
      end
      cnt = m_count();
      case (m_mode)
        0: if (sb.drain_req) m_mode = (cnt == 0) ? 2 : 1;
        1: if (!sb.drain_req) m_mode = 0; else if (cnt == 0) m_mode = 2;
        default: if (!sb.drain_req) m_mode = 0;
      endcase
    end
    #1;
    check({tag, ".busy"},      64'(sb.busy), 64'(m_vec()));
    check({tag, ".inflight"},  64'(sb.inflight), 64'(m_count()));
    check({tag, ".quiescent"}, 64'(sb.quiescent), 64'(m_mode == 2));
    check({tag, ".wb_error"},  64'(sb.wb_error), 64'(m_err));
    @(negedge clock);
  endtask

  initial begin
    int q[$];
    int pick;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_mode = 0;
    m_err  = 0;
    idle();
    sb.drain_req = 1'b0;
    sb.scan      = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    tick("post_rst");
    check("rst.stall_idle", 64'(sb.stall), 64'd0);

    // RAW on x5 resolved by writeback, no bypass
    set_issue(1, 0, 0, 0, 0, 5, 1);
    tick("raw.w5");
    check("raw.busy5", 64'(sb.busy[5]), 64'd1);
    set_issue(1, 5, 1, 0, 0, 0, 0);
    tick("raw.stall_a");
    tick("raw.stall_b");
    set_wb(1, 5);
    tick("raw.wb5");
    set_wb(0, 0);
    #1 check("raw.fire_after_wb", 64'(sb.issue_fire), 64'd1);
    #1;
    @(negedge clock);
    tick("raw.fire");
    idle();
    tick("raw.idle");

    // capacity limit
    for (int r = 1; r <= 4; r++) begin
      set_issue(1, 0, 0, 0, 0, r, 1);
      tick("cap.fill");
    end
    set_issue(1, 0, 0, 0, 0, 6, 1);
    tick("cap.full_stall");
    check("cap.inflight4", 64'(sb.inflight), 64'd4);
    set_wb(1, 2);
    tick("cap.wb2_still_stall");
    set_wb(0, 0);
    tick("cap.x6_fires");
    check("cap.inflight_stays4", 64'(sb.inflight), 64'd4);
    idle();
    foreach (q[i]) q.delete(i);
    for (int r = 1; r <= 6; r++) if (r != 2 && r != 5) begin
      set_wb(1, r);
      tick("cap.drain_wb");
    end
    idle();

    // x0 never tracked
    set_issue(1, 0, 1, 0, 1, 0, 1);
    tick("x0.write");
    check("x0.busy", 64'(sb.busy), 64'd0);
    check("x0.inflight", 64'(sb.inflight), 64'd0);

    // simultaneous fire and writeback
    set_issue(1, 0, 0, 0, 0, 3, 1);
    tick("fw.set3");
    set_issue(1, 0, 0, 0, 0, 7, 1);
    set_wb(1, 3);
    tick("fw.fire7_wb3");
    check("fw.inflight1", 64'(sb.inflight), 64'd1);
    idle();
    set_wb(1, 7);
    tick("fw.wb7");

    // spurious writeback is sticky
    set_wb(1, 9);
    tick("err.wb9");
    check("err.set", 64'(sb.wb_error), 64'd1);
    idle();
    tick("err.hold1");
    tick("err.hold2");

    // drain with two outstanding writes
    set_issue(1, 0, 0, 0, 0, 10, 1);
    tick("dr.w10");
    set_issue(1, 0, 0, 0, 0, 11, 1);
    tick("dr.w11");
    idle();
    sb.drain_req = 1'b1;
    tick("dr.req");
    set_issue(1, 0, 0, 0, 0, 12, 1);
    tick("dr.stall1");
    set_wb(1, 10);
    tick("dr.wb10");
    set_wb(1, 11);
    tick("dr.wb11");
    set_wb(0, 0);
    check("dr.quiescent", 64'(sb.quiescent), 64'd1);
    tick("dr.q_hold");
    sb.drain_req = 1'b0;
    tick("dr.release");
    tick("dr.pending_fires");
    idle();
    set_wb(1, 12);
    tick("dr.wb12");
    idle();

    // flush mid-drain
    set_issue(1, 0, 0, 0, 0, 13, 1);
    tick("fl.w13");
    set_issue(1, 0, 0, 0, 0, 14, 1);
    tick("fl.w14");
    idle();
    sb.drain_req = 1'b1;
    tick("fl.req");
    sb.flush = 1'b1;
    set_wb(1, 13);
    tick("fl.flush");
    check("fl.quiescent", 64'(sb.quiescent), 64'd1);
    check("fl.busy0", 64'(sb.busy), 64'd0);
    idle();
    sb.drain_req = 1'b0;
    tick("fl.release");

    // reset mid-flight, stale writeback afterwards
    set_issue(1, 0, 0, 0, 0, 15, 1);
    tick("rs.w15");
    idle();
    reset = 1'b1;
    tick("rs.reset");
    reset = 1'b0;
    check("rs.err_clr", 64'(sb.wb_error), 64'd0);
    set_wb(1, 15);
    tick("rs.stale_wb");
    idle();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      bit wr;
      set_issue($urandom_range(9, 0) < 7, $urandom_range(7, 0), $urandom_range(1, 0),
                $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                $urandom_range(3, 0) != 0);
      q.delete();
      for (int i = 1; i < NR; i++) if (m_busy[i]) q.push_back(i);
      wr = ($urandom_range(1, 0) == 1);
      if (q.size() > 0 && $urandom_range(99, 0) < 85) begin
        pick = q[$urandom_range(q.size() - 1, 0)];
        set_wb(wr, pick);
      end else begin
        set_wb(wr, $urandom_range(NR - 1, 0));
      end
      sb.flush = ($urandom_range(99, 0) < 3);
      if ($urandom_range(99, 0) < 6) sb.drain_req = ~sb.drain_req;
      reset = ($urandom_range(199, 0) == 0);
      tick("rnd");
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register scoreboard and issue controller for the 32-bit decode stage. Tracks which architectural registers have a write in flight and stalls decode on RAW/WAW hazards or when the in-flight limit is reached. Sits between `decode_unit` and the execute/writeback path; its `stall` gates PC and instruction advance. Also provides a drain/quiesce handshake for flushes, CSR writes and debug halts.

## Interface
- `CORE`, 0, core index printed in scan output
- `REG_SEL_BITS`, 5, register index width (2^REG_SEL_BITS registers)
- `MAX_INFLIGHT`, 4, maximum outstanding register writes (1..31)
- `SCAN_CYCLES_MIN`, 0, first cycle of scan printing
- `SCAN_CYCLES_MAX`, 1000, last cycle of scan printing
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `issue_valid`  in  1  decode holds a valid instruction
- `issue_rs1`, `issue_rs2`, `issue_rd`  in  REG_SEL_BITS  source and destination indices
- `uses_rs1`, `uses_rs2`, `writes_rd`  in  1  operand-usage qualifiers from control
- `wb_valid`  in  1  writeback commits this cycle
- `wb_reg`  in  REG_SEL_BITS  writeback destination
- `flush`  in  1  squash all in-flight tracking
- `drain_req`  in  1  level request to quiesce the pipe
- `scan`  in  1  enable debug printing
- `stall`  out  1  decode must hold
- `issue_fire`  out  1  instruction accepted this cycle
- `quiescent`  out  1  drain complete, no writes outstanding
- `busy`  out  2^REG_SEL_BITS  per-register pending-write vector
- `inflight`  out  $clog2(MAX_INFLIGHT+1)  outstanding write count
- `wb_error`  out  1  sticky: writeback to non-busy register

## Operation
- `busy[0]` is hardwired to 0; rd=0 and wb_reg=0 never set or clear state and never count.
- hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & rd≠0 & busy[rd]) | (writes_rd & rd≠0 & inflight==MAX_INFLIGHT).
- stall = issue_valid & (hazard | state≠RUN | flush). issue_fire = issue_valid & ~stall.
- No writeback bypass: a wb in cycle N clears busy at N+1; a dependent instruction stalls in cycle N and fires at N+1 at the earliest.
- On issue_fire & writes_rd & rd≠0: set busy[rd], inflight+1.
- On wb_valid & wb_reg≠0 & busy[wb_reg]: clear busy[wb_reg], inflight−1. If busy[wb_reg]=0: no state change, set wb_error.
- Fire and wb in the same cycle: both applied; net inflight change is 0. The same register cannot be both set and cleared legally (a WAW stall prevents it); if it occurs, the set wins and wb_error is raised.
- flush: next cycle busy=0, inflight=0; issue and wb in the flush cycle are ignored; wb_error is preserved.
- FSM states: RUN, DRAIN, QUIESCENT.
  - RUN→DRAIN when drain_req=1.
  - DRAIN→QUIESCENT when the next inflight value is 0.
  - QUIESCENT→RUN when drain_req=0.
  - DRAIN→RUN if drain_req drops before completion.
  - flush during DRAIN forces QUIESCENT next cycle if drain_req is still 1.
- quiescent = (state==QUIESCENT).
- scan: per-cycle $display of state, busy, inflight and stall cause, within the cycle window.

## Timing
- Reset values: busy=0, inflight=0, state=RUN, wb_error=0, cycle counter=0. stall, issue_fire and quiescent are 0 while issue_valid=0 after reset.
- stall and issue_fire are combinational from inputs plus state; they must settle in the same cycle as decode.
- Register updates take effect on the next posedge; busy and inflight are registered outputs.
- Drain latency: quiescent rises the cycle after the last outstanding wb; it rises 1 cycle after drain_req if inflight is already 0.
- Reset mid-drain or mid-flight returns the block to reset values; wb arriving after reset sets wb_error.

## Structure
- Shared package `brisc_pkg`: FSM state typedef `sb_state_t` {RUN, DRAIN, QUIESCENT}, REG_SEL_BITS default, stall-cause encoding for scan.
- One natural combinational sub-module: `hazard_check` (busy vector plus indices → hazard, cause). The top level holds the busy register, counter, FSM and scan.

## Test plan
- Issue x5 write (rd=5) with no rs use, then next cycle rs1=5 → cycle 1 fire, busy[5]=1, inflight=1; cycle 2 stall=1; wb_reg=5 at cycle 4 → fire at cycle 5, busy[5]=0.
- Four writes to x1..x4 with no wb, then a write to x6 → 5th stalls (inflight=4); wb x2 → x6 fires the next cycle, inflight stays 4.
- Write with rd=0 and source rs1=0 → never stalls, busy=0, inflight=0.
- Fire rd=7 and wb x3 in the same cycle (x3 busy) → busy[7]=1, busy[3]=0, inflight unchanged.
- wb_reg=9 while busy[9]=0 → wb_error=1 sticky until reset; inflight unchanged.
- inflight=2, assert drain_req → stall=1 for all issues; after both wbs quiescent=1 on the next cycle; drop drain_req → RUN, pending instruction fires. Repeat with flush mid-drain → quiescent the next cycle, busy=0.
